// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - push-button conditioner signal bundle
//
// Purpose: groups the button-side signals of button_conditioner.
// Signals:
//   btn_raw   [4:0]  raw asynchronous buttons, [4]=C [3]=R [2]=L [1]=U [0]=D
//   btn_level [4:0]  debounced level per button
//   btn_pulse [4:0]  one-cycle press / auto-repeat strobe per button
//   btn_any          OR of btn_level
// Modports:
//   master  drives btn_raw, consumes the conditioned outputs
//   slave   the conditioner itself
interface button_conditioner_if;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       btn_any;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_any
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_any
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and auto-repeat five push-buttons
//
// Purpose: each raw button passes through a 2-flop synchronizer and an
// independent debounce counter; an accepted press produces a one-cycle
// strobe, and buttons selected by REPEAT_MASK keep strobing while held
// (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   btn    button_conditioner_if.slave (btn_raw in; btn_level, btn_pulse,
//          btn_any out, all registered)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter logic [4:0]  REPEAT_MASK     = 5'b00011
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  btn
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_MAX = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_MAX = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DELAY = 2'd1,
    REPEATING  = 2'd2
  } rpt_state_t;

  // synchronizer
  logic [4:0] sync_meta;
  logic [4:0] sync_q;

  // debounce
  logic [DB_W-1:0] db_cnt [5];
  logic [4:0]      level_q;
  logic [4:0]      accept;
  logic [4:0]      rise;
  logic [4:0]      fall;
  logic [4:0]      level_d;

  // repeat FSMs
  rpt_state_t      state_q   [5];
  rpt_state_t      state_d   [5];
  logic [RP_W-1:0] rpt_cnt_q [5];
  logic [RP_W-1:0] rpt_cnt_d [5];

  // outputs
  logic [4:0] pulse_d;
  logic [4:0] pulse_q;
  logic       any_q;

  // ------------------------------------------------------------------
  // 2-flop synchronizer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn.btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // ------------------------------------------------------------------
  // Debounce: a level change is accepted on the edge where the counter
  // has already seen DEBOUNCE_CYCLES-1 consecutive differing samples and
  // the sample still differs.
  // ------------------------------------------------------------------
  always_comb begin
    accept = '0;
    for (int i = 0; i < 5; i++) begin
      accept[i] = (sync_q[i] != level_q[i]) && (db_cnt[i] == DB_MAX);
    end
    rise    = accept & sync_q;
    fall    = accept & ~sync_q;
    level_d = level_q ^ accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        db_cnt[i] <= '0;
      end
      level_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if ((sync_q[i] == level_q[i]) || accept[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
      level_q <= level_d;
    end
  end

  // ------------------------------------------------------------------
  // Repeat FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i]   <= IDLE;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Repeat FSM: next state. The counter restarts at every emitted repeat,
  // so it never exceeds REPEAT_DELAY-1 and cannot wrap however long the
  // button is held. Masked-off buttons are pinned in IDLE.
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!REPEAT_MASK[i] || fall[i]) begin
        state_d[i]   = IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              state_d[i]   = WAIT_DELAY;
              rpt_cnt_d[i] = '0;
            end
          end
          WAIT_DELAY: begin
            if (rpt_cnt_q[i] == DELAY_MAX) begin
              state_d[i]   = REPEATING;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RP_W'(1);
            end
          end
          REPEATING: begin
            if (rpt_cnt_q[i] == PERIOD_MAX) begin
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RP_W'(1);
            end
          end
          default: begin
            state_d[i]   = IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------------
  // Repeat FSM: outputs. A release accepted on the same edge as a due
  // repeat suppresses that repeat.
  // ------------------------------------------------------------------
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < 5; i++) begin
      pulse_d[i] = rise[i] ||
                   (REPEAT_MASK[i] && !fall[i] &&
                    (((state_q[i] == WAIT_DELAY) && (rpt_cnt_q[i] == DELAY_MAX)) ||
                     ((state_q[i] == REPEATING)  && (rpt_cnt_q[i] == PERIOD_MAX))));
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      any_q   <= |level_d;
    end
  end

  assign btn.btn_level = level_q;
  assign btn.btn_pulse = pulse_q;
  assign btn.btn_any   = any_q;

endmodule
